// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the direct-mapped data cache.
package dcache_pkg;

    localparam int unsigned TAG_W  = 22;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned OFS_W  = 5;
    localparam int unsigned WSEL_W = 3;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned N_LINES = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_e;

    // Byte address split into cache fields; the two low bits are ignored.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  idx;
        logic [WSEL_W-1:0] word;
        logic [1:0]        byte_ofs;
    } addr_t;

    function automatic addr_t split_addr(input logic [31:0] a);
        return addr_t'(a);
    endfunction

    // Line-aligned memory address for a given tag and index.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx);
        return {tag, idx, {OFS_W{1'b0}}};
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input logic [LINE_W-1:0]  line,
                                                  input logic [WSEL_W-1:0] sel);
        return line[{sel, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU data-access port and line-wide main-memory port of the data cache.
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_BITS = LINE_W
) ();

    // CPU side
    logic              req_i;
    logic              write_i;
    logic [31:0]       addr_i;
    logic [WORD_W-1:0] wdata_i;
    logic [WORD_W-1:0] rdata_o;
    logic              stall_o;

    // Memory side
    logic                 mem_enable_o;
    logic                 mem_write_o;
    logic [31:0]          mem_addr_o;
    logic [LINE_BITS-1:0] mem_data_o;
    logic                 mem_ack_i;
    logic [LINE_BITS-1:0] mem_data_i;

    // Cache controller view
    modport slave (
        input  req_i, write_i, addr_i, wdata_i, mem_ack_i, mem_data_i,
        output rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    // CPU plus memory environment view
    modport master (
        output req_i, write_i, addr_i, wdata_i, mem_ack_i, mem_data_i,
        input  rdata_o, stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data arrays: one combinational read port, one write port
// that either refills a whole line or stores a single word.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = N_LINES,
    parameter int unsigned LINE_BITS = LINE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic                 rd_dirty,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_data,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic                 wr_line,
    input  logic                 wr_word,
    input  logic [WSEL_W-1:0]    wr_word_sel,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line_data,
    input  logic [WORD_W-1:0]    wr_word_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    // Asynchronous read of the addressed line.
    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_dirty = dirty_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_data  = data_q[rd_idx];
    end

    // Status bits: refill leaves the line clean, a word store marks it dirty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_line) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= 1'b0;
        end else if (wr_word) begin
            dirty_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, no reset needed.
    always_ff @(posedge clk) begin
        if (wr_line) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line_data;
        end else if (wr_word) begin
            data_q[wr_idx][{wr_word_sel, 5'b0} +: WORD_W] <= wr_word_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back write-allocate data cache controller: hits complete
// in the same cycle, misses stall while a dirty victim is written back and the
// line is refilled, after which the held request completes as a hit.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int unsigned NUM_LINES = N_LINES,
    parameter int unsigned LINE_BITS = LINE_W
) (
    input  logic     clk_i,
    input  logic     rst_i,
    dcache_if.slave  bus
);

    state_e               state_q, state_d;
    logic [TAG_W-1:0]     lat_tag_q, lat_tag_d;
    logic [IDX_W-1:0]     lat_idx_q, lat_idx_d;
    logic                 mem_en_q, mem_en_d;
    logic                 mem_wr_q, mem_wr_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;

    addr_t                req_a;
    logic                 unused_ofs;
    logic [IDX_W-1:0]     arr_idx;
    logic                 rd_valid, rd_dirty;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_BITS-1:0] rd_data;
    logic                 hit, stall;
    logic                 wr_line, wr_word;

    // Outside IDLE the arrays are addressed by the latched miss, not the CPU.
    always_comb begin
        req_a      = split_addr(bus.addr_i);
        unused_ofs = ^req_a.byte_ofs;
        arr_idx    = (state_q == IDLE) ? req_a.idx : lat_idx_q;
        hit        = rd_valid & (rd_tag == req_a.tag);
        stall      = bus.req_i & (~hit | (state_q != IDLE));
    end

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_BITS (LINE_BITS)
    ) u_sram (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .rd_idx       (arr_idx),
        .rd_valid     (rd_valid),
        .rd_dirty     (rd_dirty),
        .rd_tag       (rd_tag),
        .rd_data      (rd_data),
        .wr_idx       (arr_idx),
        .wr_line      (wr_line),
        .wr_word      (wr_word),
        .wr_word_sel  (req_a.word),
        .wr_tag       (lat_tag_q),
        .wr_line_data (bus.mem_data_i),
        .wr_word_data (bus.wdata_i)
    );

    // CPU-facing outputs; load data only while the access is completing.
    always_comb begin
        bus.stall_o = stall;
        bus.rdata_o = (bus.req_i && !stall) ? word_of(rd_data, req_a.word) : '0;
    end

    // Next state, request latch, memory command and array write strobes.
    always_comb begin
        state_d    = state_q;
        lat_tag_d  = lat_tag_q;
        lat_idx_d  = lat_idx_q;
        mem_en_d   = mem_en_q;
        mem_wr_d   = mem_wr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wr_line    = 1'b0;
        wr_word    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    if (hit) begin
                        wr_word = bus.write_i;
                    end else begin
                        lat_tag_d = req_a.tag;
                        lat_idx_d = req_a.idx;
                        mem_en_d  = 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_d    = WRITEBACK;
                            mem_wr_d   = 1'b1;
                            mem_addr_d = line_addr(rd_tag, req_a.idx);
                            mem_data_d = rd_data;
                        end else begin
                            state_d    = ALLOCATE;
                            mem_wr_d   = 1'b0;
                            mem_addr_d = line_addr(req_a.tag, req_a.idx);
                        end
                    end
                end
            end
            WRITEBACK: begin
                // Enable stays high; the write-bit drop starts the fetch.
                if (bus.mem_ack_i) begin
                    state_d    = ALLOCATE;
                    mem_wr_d   = 1'b0;
                    mem_addr_d = line_addr(lat_tag_q, lat_idx_q);
                end
            end
            ALLOCATE: begin
                if (bus.mem_ack_i) begin
                    wr_line  = 1'b1;
                    state_d  = IDLE;
                    mem_en_d = 1'b0;
                    mem_wr_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched miss and registered memory command.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            lat_tag_q  <= '0;
            lat_idx_q  <= '0;
            mem_en_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_tag_q  <= lat_tag_d;
            lat_idx_q  <= lat_idx_d;
            mem_en_q   <= mem_en_d;
            mem_wr_q   <= mem_wr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Memory command straight from registers.
    always_comb begin
        bus.mem_enable_o = mem_en_q;
        bus.mem_write_o  = mem_wr_q;
        bus.mem_addr_o   = mem_addr_q;
        bus.mem_data_o   = mem_data_q;
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by random
// loads/stores, checked against a word-level view of memory plus a simple
// line-presence model that predicts hits, write-backs and stall lengths.
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_if bus ();
    logic mdl_ack = 1'b0;
    logic stray_ack = 1'b0;
    assign bus.mem_ack_i = mdl_ack | stray_ack;

    dcache_ctrl #(
        .NUM_LINES (32),
        .LINE_BITS (256)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned lat = 3;

    // Backing memory, keyed by line number; untouched lines hold a fixed pattern.
    logic [255:0] mem [int unsigned];

    function automatic logic [31:0] orig_word(input int unsigned ln, input int unsigned w);
        logic [31:0] wv;
        wv = w;
        if (ln == 32'h20) return 32'h1111_1111 * (wv + 1);
        return (ln * 32'h9E37_79B9) ^ {wv[7:0], 24'h5A_5A5A};
    endfunction

    function automatic logic [255:0] mem_line(input int unsigned ln);
        logic [255:0] l;
        if (mem.exists(ln)) return mem[ln];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = orig_word(ln, w);
        return l;
    endfunction

    // Memory responder: acks in the lat-th cycle of each transaction.
    initial begin : mem_model
        int unsigned cnt;
        logic        p_en, p_wr, p_ack, new_txn;
        logic [31:0] p_addr;
        cnt = 0; p_en = 0; p_wr = 0; p_ack = 0; p_addr = 0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                cnt = 0; p_en = 0; p_ack = 0; mdl_ack = 0;
            end else begin
                mdl_ack = 1'b0;
                if (bus.mem_enable_o) begin
                    new_txn = !p_en || p_ack || (bus.mem_write_o != p_wr) ||
                              (bus.mem_addr_o != p_addr);
                    cnt = new_txn ? 1 : cnt + 1;
                    if (cnt == lat) begin
                        mdl_ack = 1'b1;
                        if (bus.mem_write_o) mem[bus.mem_addr_o >> 5] = bus.mem_data_o;
                        else bus.mem_data_i = mem_line(bus.mem_addr_o >> 5);
                    end
                end else begin
                    cnt = 0;
                end
                p_en = bus.mem_enable_o; p_wr = bus.mem_write_o;
                p_addr = bus.mem_addr_o; p_ack = mdl_ack;
            end
        end
    end

    // Reference: what the CPU should read, what memory should hold, and
    // which line each index currently caches.
    logic [31:0] cpu_view [int unsigned];
    logic [31:0] mem_view [int unsigned];
    bit          r_valid [32];
    bit          r_dirty [32];
    logic [21:0] r_tag   [32];

    function automatic logic [31:0] cpu_word(input int unsigned wa);
        if (cpu_view.exists(wa)) return cpu_view[wa];
        return orig_word(wa >> 3, wa & 7);
    endfunction

    function automatic logic [255:0] line_view(input int unsigned ln);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = cpu_word(ln * 8 + w);
        return l;
    endfunction

    // Cached stores that never reached memory are lost on reset.
    task automatic ref_reset();
        for (int i = 0; i < 32; i++) begin
            r_valid[i] = 0; r_dirty[i] = 0; r_tag[i] = '0;
        end
        cpu_view = mem_view;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input string tag);
        logic [21:0]  t;
        logic [4:0]   idx;
        int unsigned  wa, exp_stall, exp_ntxn, stalls, vln;
        bit           exp_hit, exp_dirty;
        logic [31:0]  exp_wb_addr, exp_fetch_addr, exp_rdata;
        logic [255:0] exp_wb_data, seen_wb_data;
        logic [31:0]  txn_addr [$];
        bit           txn_wr [$];
        logic         pen, pwr;
        logic [31:0]  paddr;

        t = addr[31:10]; idx = addr[9:5]; wa = addr >> 2;
        exp_hit   = r_valid[idx] && (r_tag[idx] == t);
        exp_dirty = !exp_hit && r_valid[idx] && r_dirty[idx];
        exp_stall = exp_hit ? 0 : (exp_dirty ? 2 * lat + 1 : lat + 1);
        exp_ntxn  = exp_hit ? 0 : (exp_dirty ? 2 : 1);
        exp_wb_addr    = {r_tag[idx], idx, 5'b0};
        exp_fetch_addr = {t, idx, 5'b0};
        vln = exp_wb_addr >> 5;
        exp_wb_data = line_view(vln);
        if (exp_dirty)
            for (int w = 0; w < 8; w++) mem_view[vln * 8 + w] = cpu_word(vln * 8 + w);
        if (!exp_hit) begin
            r_valid[idx] = 1; r_tag[idx] = t; r_dirty[idx] = 0;
        end
        exp_rdata = cpu_word(wa);
        if (wr) begin
            r_dirty[idx] = 1;
            cpu_view[wa] = wd;
        end

        @(negedge clk);
        bus.req_i = 1'b1; bus.write_i = wr; bus.addr_i = addr; bus.wdata_i = wd;
        #1;
        stalls = 0; pen = 0; pwr = 0; paddr = 0; seen_wb_data = '0;
        while (bus.stall_o && stalls < 200) begin
            stalls++;
            if (stalls == 1) chk({tag, "_rdata_stalled"}, bus.rdata_o, 0);
            if (bus.mem_enable_o && (!pen || pwr != bus.mem_write_o || paddr != bus.mem_addr_o)) begin
                txn_addr.push_back(bus.mem_addr_o);
                txn_wr.push_back(bus.mem_write_o);
                if (bus.mem_write_o) seen_wb_data = bus.mem_data_o;
            end
            pen = bus.mem_enable_o; pwr = bus.mem_write_o; paddr = bus.mem_addr_o;
            @(posedge clk);
            #1;
        end
        chk({tag, "_stall_cycles"}, stalls, exp_stall);
        chk({tag, "_mem_txns"}, txn_addr.size(), exp_ntxn);
        chk({tag, "_mem_enable_done"}, bus.mem_enable_o, 0);
        if (txn_addr.size() == exp_ntxn && exp_ntxn == 2) begin
            chk({tag, "_wb_is_write"}, txn_wr[0], 1);
            chk({tag, "_wb_addr"}, txn_addr[0], exp_wb_addr);
            chk({tag, "_wb_data"}, seen_wb_data, exp_wb_data);
        end
        if (txn_addr.size() == exp_ntxn && exp_ntxn > 0) begin
            chk({tag, "_fetch_is_read"}, txn_wr[exp_ntxn-1], 0);
            chk({tag, "_fetch_addr"}, txn_addr[exp_ntxn-1], exp_fetch_addr);
        end
        if (!wr) chk({tag, "_rdata"}, bus.rdata_o, exp_rdata);
        @(posedge clk);
        #1;
        bus.req_i = 1'b0; bus.write_i = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int waited, k;
        logic [31:0] a;
        bus.req_i = 0; bus.write_i = 0; bus.addr_i = 0; bus.wdata_i = 0;
        ref_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_stall", bus.stall_o, 0);
        chk("reset_mem_enable", bus.mem_enable_o, 0);
        chk("reset_mem_write", bus.mem_write_o, 0);
        chk("reset_mem_addr", bus.mem_addr_o, 0);
        chk("reset_mem_data", bus.mem_data_o, 0);
        chk("reset_rdata", bus.rdata_o, 0);
        @(negedge clk);
        rst_n = 1'b1;

        lat = 3;
        access(0, 32'h0000_0400, 0, "ld_400_clean_miss");
        access(0, 32'h0000_0404, 0, "ld_404_hit");
        access(1, 32'h0000_0400, 32'hDEAD_BEEF, "st_400_hit");
        access(0, 32'h0000_0800, 0, "ld_800_dirty_miss");
        access(0, 32'h0000_0C20, 0, "ld_c20_clean_miss");
        access(0, 32'h0000_0020, 0, "ld_020_evict_clean");

        // Reset while the refill is outstanding.
        lat = 5;
        @(negedge clk);
        bus.req_i = 1; bus.write_i = 0; bus.addr_i = 32'h0000_1040;
        #1;
        waited = 0;
        while (!(bus.mem_enable_o && !bus.mem_write_o) && waited < 20) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("rst_reached_allocate", waited < 20, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_enable", bus.mem_enable_o, 0);
        chk("rst_mid_mem_write", bus.mem_write_o, 0);
        @(negedge clk);
        bus.req_i = 0;
        rst_n = 1'b1;
        ref_reset();
        lat = 3;
        access(0, 32'h0000_0400, 0, "ld_400_after_rst");

        // Idle with a stray ack.
        k = $urandom_range(0, 9);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            stray_ack = (i == k);
            #1;
            chk("idle_stall", bus.stall_o, 0);
            chk("idle_mem_enable", bus.mem_enable_o, 0);
            chk("idle_rdata", bus.rdata_o, 0);
        end
        @(negedge clk);
        stray_ack = 1'b0;
        access(0, 32'h0000_0408, 0, "ld_408_hit_after_idle");

        // Random traffic over a few tags and indices to force conflicts.
        for (int i = 0; i < 150; i++) begin
            lat = $urandom_range(1, 4);
            a = {20'h0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), a, $urandom, "rnd");
            if ($urandom_range(0, 7) == 0) repeat (2) @(posedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
